// File: rtl/dmem_arbiter_if.sv
// Requester-side bus for the data memory arbiter.
// One instance per requester (CPU load/store stage, DMA/debug loader).
//   req/we/lock/addr/wdata : request fields, driven by the requester (master)
//   gnt                    : access issued this cycle (combinational from arbiter)
//   rvalid/rdata           : registered read return, one cycle after a read grant
interface dmem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              req;
   logic              we;
   logic              lock;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, we, lock, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, lock, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing the single-port data memory between the CPU
// load/store stage (port_a) and a DMA/debug loader (port_b).
// One access per cycle, round-robin between requesters, with an optional
// bounded lock so one side can hold the memory for short bursts.
//   clk, rst_n          : system clock, synchronous active-low reset
//   port_a, port_b      : requester buses (slave side)
//   mem_access_addr     : address to memory (byte address, passed through)
//   mem_write_data      : write data to memory
//   mem_write_en        : write strobe, applied at the end of the grant cycle
//   mem_read            : read strobe
//   mem_read_data       : combinational read data from memory
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | nobody holds the memory; plain round-robin
// OWN_A | port_a holds a lock; it wins while requesting and lock_cnt<LOCK_MAX
// OWN_B | port_b holds a lock; it wins while requesting and lock_cnt<LOCK_MAX
module dmem_arbiter #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int LOCK_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   dmem_arbiter_if.slave     port_a,
   dmem_arbiter_if.slave     port_b,
   output logic [ADDR_W-1:0] mem_access_addr,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_write_en,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_read_data
);

   typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} owner_t;

   localparam int              CW         = $clog2(LOCK_MAX + 1);
   localparam logic [CW-1:0]   LOCK_MAX_C = CW'(LOCK_MAX);
   localparam logic [CW-1:0]   CNT_ONE    = CW'(1);

   owner_t            owner;
   logic              last_srv_b;
   logic [CW-1:0]     lock_cnt;
   logic              win_a;
   logic              win_b;
   logic              rvalid_a_q;
   logic              rvalid_b_q;
   logic [DATA_W-1:0] rdata_a_q;
   logic [DATA_W-1:0] rdata_b_q;

   // Once the lock budget is used up the holder falls through to round-robin;
   // since last_srv is the holder, an active other side wins, otherwise the
   // holder keeps going and its count restarts.
   always_comb begin
      win_a = 1'b0;
      win_b = 1'b0;
      if (rst_n) begin
         if (owner == OWN_A && port_a.req && lock_cnt < LOCK_MAX_C)
            win_a = 1'b1;
         else if (owner == OWN_B && port_b.req && lock_cnt < LOCK_MAX_C)
            win_b = 1'b1;
         else if (port_a.req && port_b.req) begin
            if (last_srv_b) win_a = 1'b1;
            else            win_b = 1'b1;
         end
         else if (port_a.req)
            win_a = 1'b1;
         else if (port_b.req)
            win_b = 1'b1;
      end
   end

   always_comb begin
      mem_access_addr = '0;
      mem_write_data  = '0;
      mem_write_en    = 1'b0;
      mem_read        = 1'b0;
      if (win_a) begin
         mem_access_addr = port_a.addr;
         mem_write_data  = port_a.wdata;
         mem_write_en    = port_a.we;
         mem_read        = ~port_a.we;
      end
      else if (win_b) begin
         mem_access_addr = port_b.addr;
         mem_write_data  = port_b.wdata;
         mem_write_en    = port_b.we;
         mem_read        = ~port_b.we;
      end
   end

   assign port_a.gnt    = win_a;
   assign port_b.gnt    = win_b;
   // Masked so a read granted just before reset never shows a return pulse.
   assign port_a.rvalid = rvalid_a_q & rst_n;
   assign port_b.rvalid = rvalid_b_q & rst_n;
   assign port_a.rdata  = rdata_a_q;
   assign port_b.rdata  = rdata_b_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         owner      <= IDLE;
         last_srv_b <= 1'b1;
         lock_cnt   <= '0;
         rvalid_a_q <= 1'b0;
         rvalid_b_q <= 1'b0;
         rdata_a_q  <= '0;
         rdata_b_q  <= '0;
      end
      else begin
         rvalid_a_q <= win_a & ~port_a.we;
         rvalid_b_q <= win_b & ~port_b.we;
         if (win_a && !port_a.we) rdata_a_q <= mem_read_data;
         if (win_b && !port_b.we) rdata_b_q <= mem_read_data;

         if (win_a || win_b) last_srv_b <= win_b;

         if (win_a && port_a.lock) begin
            owner    <= OWN_A;
            lock_cnt <= (owner == OWN_A && lock_cnt < LOCK_MAX_C) ?
                        lock_cnt + CNT_ONE : CNT_ONE;
         end
         else if (win_b && port_b.lock) begin
            owner    <= OWN_B;
            lock_cnt <= (owner == OWN_B && lock_cnt < LOCK_MAX_C) ?
                        lock_cnt + CNT_ONE : CNT_ONE;
         end
         else begin
            owner    <= IDLE;
            lock_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dmem_arbiter_if ia ();
   dmem_arbiter_if ib ();

   logic [15:0] mem_access_addr;
   logic [15:0] mem_write_data;
   logic        mem_write_en;
   logic        mem_read;
   logic [15:0] mem_read_data;

   dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .LOCK_MAX(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .port_a          (ia),
      .port_b          (ib),
      .mem_access_addr (mem_access_addr),
      .mem_write_data  (mem_write_data),
      .mem_write_en    (mem_write_en),
      .mem_read        (mem_read),
      .mem_read_data   (mem_read_data)
   );

   // memory model: word index from addr[9:2], combinational read
   logic [15:0] mem [256];
   initial for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
   always @(posedge clk) if (mem_write_en) mem[mem_access_addr[9:2]] <= mem_write_data;
   assign mem_read_data = mem[mem_access_addr[9:2]];

   typedef struct {
      bit          port;
      bit          we;
      logic [15:0] addr;
      logic [15:0] data;
      int          cyc;
   } ev_t;

   ev_t gq[$];
   ev_t rq[$];
   int  cyc   = 0;
   int  tests = 0;
   int  fails = 0;
   bit  rst_q = 1'b0;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst_n;
   end

   // monitor
   always @(negedge clk) begin
      ev_t         e;
      logic        rv [2];
      logic [15:0] rd [2];
      rv[0] = ia.rvalid; rv[1] = ib.rvalid;
      rd[0] = ia.rdata;  rd[1] = ib.rdata;
      if (!rst_n) begin
         tests++;
         if (ia.gnt || ib.gnt || ia.rvalid || ib.rvalid || mem_write_en || mem_read ||
             mem_access_addr != 16'h0 || mem_write_data != 16'h0) begin
            fails++;
            $display("FAIL reset_outputs: gnt=%b%b rvalid=%b%b we=%b rd=%b addr=%h wdata=%h, expected all 0",
                     ia.gnt, ib.gnt, ia.rvalid, ib.rvalid, mem_write_en, mem_read,
                     mem_access_addr, mem_write_data);
         end
         if (!rst_q) begin
            tests++;
            if (ia.rdata != 16'h0 || ib.rdata != 16'h0) begin
               fails++;
               $display("FAIL reset_rdata: a_rdata=%h b_rdata=%h, expected 0000 0000", ia.rdata, ib.rdata);
            end
         end
      end
      else begin
         if (ia.gnt && ib.gnt) begin
            tests++; fails++;
            $display("FAIL both_gnt: a_gnt=1 b_gnt=1 at cyc %0d, expected one-hot", cyc);
         end
         else if (ia.gnt || ib.gnt) begin
            tests++;
            if (gq.size() == 0) begin
               fails++;
               $display("FAIL grant_unexpected: port=%0d at cyc %0d, expected no grant", ib.gnt, cyc);
            end
            else begin
               e = gq.pop_front();
               if (ib.gnt != e.port || mem_write_en != e.we || mem_read != !e.we ||
                   mem_access_addr != e.addr || mem_write_data != e.data || cyc != e.cyc) begin
                  fails++;
                  $display("FAIL grant: port=%0d we=%b rd=%b addr=%h wdata=%h cyc=%0d, expected port=%0d we=%b addr=%h wdata=%h cyc=%0d",
                           ib.gnt, mem_write_en, mem_read, mem_access_addr, mem_write_data, cyc,
                           e.port, e.we, e.addr, e.data, e.cyc);
               end
            end
         end
         for (int p = 0; p < 2; p++) begin
            if (rv[p]) begin
               tests++;
               if (rq.size() == 0) begin
                  fails++;
                  $display("FAIL rvalid_unexpected: port=%0d data=%h at cyc %0d, expected none", p, rd[p], cyc);
               end
               else begin
                  e = rq.pop_front();
                  if (p != int'(e.port) || rd[p] != e.data || cyc != e.cyc) begin
                     fails++;
                     $display("FAIL rdata: port=%0d data=%h cyc=%0d, expected port=%0d data=%h cyc=%0d",
                              p, rd[p], cyc, e.port, e.data, e.cyc);
                  end
               end
            end
         end
      end
   end

   task automatic drive(input logic ar, input logic aw, input logic al,
                        input logic [15:0] aa, input logic [15:0] ad,
                        input logic br, input logic bw, input logic bl,
                        input logic [15:0] ba, input logic [15:0] bd);
      ia.req = ar; ia.we = aw; ia.lock = al; ia.addr = aa; ia.wdata = ad;
      ib.req = br; ib.we = bw; ib.lock = bl; ib.addr = ba; ib.wdata = bd;
   endtask

   task automatic idle();
      drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_g(input bit p, input bit we, input logic [15:0] addr, input logic [15:0] data);
      ev_t e;
      e.port = p; e.we = we; e.addr = addr; e.data = data; e.cyc = cyc;
      gq.push_back(e);
   endtask

   task automatic exp_r(input bit p, input logic [15:0] data);
      ev_t e;
      e.port = p; e.we = 1'b0; e.addr = 16'h0; e.data = data; e.cyc = cyc + 1;
      rq.push_back(e);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      idle();
      tick();
      do_reset();

      // 1: B writes BEEF to 0x0008, A reads it next cycle
      drive(0, 0, 0, 16'h0, 16'h0, 1, 1, 0, 16'h0008, 16'hBEEF);
      exp_g(1, 1, 16'h0008, 16'hBEEF);
      tick();
      drive(1, 0, 0, 16'h0008, 16'h0, 0, 0, 0, 16'h0, 16'h0);
      exp_g(0, 0, 16'h0008, 16'h0);
      exp_r(0, 16'hBEEF);
      tick();
      idle();
      tick();

      // 5: A writes 1234 to 0x0010, B reads it next cycle
      drive(1, 1, 0, 16'h0010, 16'h1234, 0, 0, 0, 16'h0, 16'h0);
      exp_g(0, 1, 16'h0010, 16'h1234);
      tick();
      drive(0, 0, 0, 16'h0, 16'h0, 1, 0, 0, 16'h0010, 16'h0);
      exp_g(1, 0, 16'h0010, 16'h0);
      exp_r(1, 16'h1234);
      tick();
      idle();
      tick();

      // 2: both requesting, no lock -> A,B,A,B,...
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1, 1, 0, 16'h0020, 16'(16'hA000 + i), 1, 1, 0, 16'h0040, 16'(16'hB000 + i));
         if (i % 2 == 0) exp_g(0, 1, 16'h0020, 16'(16'hA000 + i));
         else            exp_g(1, 1, 16'h0040, 16'(16'hB000 + i));
         tick();
      end
      // read back the last writes of each side
      drive(1, 0, 0, 16'h0020, 16'h0, 1, 0, 0, 16'h0040, 16'h0);
      exp_g(0, 0, 16'h0020, 16'h0);
      exp_r(0, 16'hA004);
      tick();
      drive(0, 0, 0, 16'h0, 16'h0, 1, 0, 0, 16'h0040, 16'h0);
      exp_g(1, 0, 16'h0040, 16'h0);
      exp_r(1, 16'hB005);
      tick();
      idle();
      tick();

      // 3: A locked, B requesting -> A x4, B, A
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1, 1, 1, 16'h0060, 16'(16'hC000 + i), 1, 1, 0, 16'h0064, 16'(16'hD000 + i));
         if (i == 4) exp_g(1, 1, 16'h0064, 16'(16'hD000 + i));
         else        exp_g(0, 1, 16'h0060, 16'(16'hC000 + i));
         tick();
      end
      idle();
      tick();

      // 4: A locked alone for 10 cycles -> A every cycle
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1, 1, 1, 16'h0080, 16'(16'hE000 + i), 0, 0, 0, 16'h0, 16'h0);
         exp_g(0, 1, 16'h0080, 16'(16'hE000 + i));
         tick();
      end
      idle();
      tick();

      // 6: A read then reset -> no rvalid, outputs 0 in reset, first tie to A
      drive(1, 0, 0, 16'h0008, 16'h0, 0, 0, 0, 16'h0, 16'h0);
      exp_g(0, 0, 16'h0008, 16'h0);
      tick();
      rst_n = 1'b0;
      drive(1, 1, 0, 16'h0090, 16'h5555, 1, 1, 0, 16'h0094, 16'h6666);
      tick();
      tick();
      rst_n = 1'b1;
      drive(1, 1, 0, 16'h0070, 16'h6A6A, 1, 1, 0, 16'h0074, 16'h6B6B);
      exp_g(0, 1, 16'h0070, 16'h6A6A);
      tick();
      exp_g(1, 1, 16'h0074, 16'h6B6B);
      tick();
      // the writes during reset must not have reached memory
      drive(1, 0, 0, 16'h0090, 16'h0, 0, 0, 0, 16'h0, 16'h0);
      exp_g(0, 0, 16'h0090, 16'h0);
      exp_r(0, 16'h0000);
      tick();
      idle();
      tick();
      tick();

      tests++;
      if (gq.size() != 0) begin
         fails++;
         $display("FAIL grants_missing: %0d outstanding, expected 0", gq.size());
      end
      tests++;
      if (rq.size() != 0) begin
         fails++;
         $display("FAIL rvalid_missing: %0d outstanding, expected 0", rq.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
